pc_update_unit: RTL and testbench

//  Program-counter stage directly downstream of branchComparator. Consumes its

---
 rtl/pc_update_unit.sv | 136 +++++++++++++
 tb/tb_pc_update_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pc_update_unit.sv
// Next-PC stage behind branchComparator: redirects on taken branches/jumps and pulses flush.
// Define RAS_EN to build the return-address stack for call/return jumps.
module pc_update_unit #(
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              brValid,
  input  logic              isJump,
  input  logic              branchIdea,
  input  logic              fC,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc,
  output logic              flush,
  output logic              rasFull,
  output logic              rasEmpty,
  output logic              rasOvf,
  output logic              rasUnf
);

  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic              flush_q, flush_d;
  logic              take;

  assign take   = brValid & branchIdea;
  assign pc_inc = pc_q + ADDR_W'(1);
  assign pc     = pc_q;
  assign flush  = flush_q;

`ifdef RAS_EN
  localparam int unsigned IdxW = $clog2(RAS_DEPTH);
  localparam int unsigned SpW  = IdxW + 1;

  logic [SpW-1:0]    sp_q, sp_d, sp_m1;
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              push, full, empty, call, ret;

  assign full  = (sp_q == SpW'(RAS_DEPTH));
  assign empty = (sp_q == '0);
  assign sp_m1 = sp_q - SpW'(1);
  assign call  = take & isJump & ~fC;
  assign ret   = take & isJump & fC;

  always_comb begin
    pc_d    = pc_inc;
    flush_d = 1'b0;
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    if (stall) begin
      pc_d = pc_q;
    end else if (call) begin
      pc_d    = target;
      flush_d = 1'b1;
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        push = 1'b1;
        sp_d = sp_q + SpW'(1);
      end
    end else if (ret) begin
      // A return with nothing on the stack falls through as a plain sequential step.
      if (empty) begin
        unf_d = 1'b1;
      end else begin
        sp_d    = sp_m1;
        pc_d    = ras_q[sp_m1[IdxW-1:0]];
        flush_d = 1'b1;
      end
    end else if (take) begin
      pc_d    = target;
      flush_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Stack contents are don't-care after reset, so no reset on the array.
  always_ff @(posedge clk) begin
    if (push) begin
      ras_q[sp_q[IdxW-1:0]] <= pc_inc;
    end
  end

  assign rasFull  = full;
  assign rasEmpty = empty;
  assign rasOvf   = ovf_q;
  assign rasUnf   = unf_q;
`else
  logic unused_jump_flavour;
  assign unused_jump_flavour = isJump ^ fC;

  // Without a stack, calls and returns redirect to target like any taken branch.
  always_comb begin
    pc_d    = pc_inc;
    flush_d = 1'b0;
    if (stall) begin
      pc_d = pc_q;
    end else if (take) begin
      pc_d    = target;
      flush_d = 1'b1;
    end
  end

  assign rasFull  = 1'b0;
  assign rasEmpty = 1'b1;
  assign rasOvf   = 1'b0;
  assign rasUnf   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      flush_q <= flush_d;
    end
  end

endmodule

// File: tb/tb_pc_update_unit.sv
// Scoreboard bench for pc_update_unit: stimulus queues expected pc/flags, a monitor checks them.
// Exercises the RAS_EN build when RAS_EN is defined, the stackless build otherwise.
module tb_pc_update_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, brValid = 1'b0, isJump = 1'b0, branchIdea = 1'b0, fC = 1'b0;
  logic [15:0] target = '0;
  logic [15:0] pc;
  logic        flush, rasFull, rasEmpty, rasOvf, rasUnf;

  // fl packs {flush, rasFull, rasEmpty, rasOvf, rasUnf}
  typedef struct {
    logic [15:0] pc;
    logic [4:0]  fl;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  pc_update_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .brValid   (brValid),
    .isJump    (isJump),
    .branchIdea(branchIdea),
    .fC        (fC),
    .target    (target),
    .pc        (pc),
    .flush     (flush),
    .rasFull   (rasFull),
    .rasEmpty  (rasEmpty),
    .rasOvf    (rasOvf),
    .rasUnf    (rasUnf)
  );

  task automatic drive(input logic rst, input logic st, input logic bv, input logic ij,
                       input logic bi, input logic fc, input logic [15:0] tgt,
                       input logic [15:0] epc, input logic [4:0] efl, input string nm);
    exp_t e;
    @(negedge clk);
    rst_n      = rst;
    stall      = st;
    brValid    = bv;
    isJump     = ij;
    branchIdea = bi;
    fC         = fc;
    target     = tgt;
    e.pc   = epc;
    e.fl   = efl;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input string nm);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 5'b00100, nm);
  endtask

  task automatic idle(input logic [15:0] epc, input logic [4:0] efl, input string nm);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, epc, efl, nm);
  endtask

  task automatic branch(input logic [15:0] tgt, input logic [15:0] epc, input logic [4:0] efl,
                        input string nm);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, tgt, epc, efl, nm);
  endtask

  task automatic call(input logic [15:0] tgt, input logic [15:0] epc, input logic [4:0] efl,
                      input string nm);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, tgt, epc, efl, nm);
  endtask

  task automatic ret(input logic [15:0] tgt, input logic [15:0] epc, input logic [4:0] efl,
                     input string nm);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, tgt, epc, efl, nm);
  endtask

  // Monitor: the DUT presents a new pc every cycle; check just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (pc !== e.pc || {flush, rasFull, rasEmpty, rasOvf, rasUnf} !== e.fl) begin
          bad++;
          $display("FAIL %s: got pc=%h flags=%b, want pc=%h flags=%b", e.name, pc,
                   {flush, rasFull, rasEmpty, rasOvf, rasUnf}, e.pc, e.fl);
        end
      end
    end
  end

  initial begin
    logic [15:0] tgt;
    logic [15:0] epc;
    int          k;

    do_reset("reset0");
    idle(16'h1, 5'b00100, "idle1");
    idle(16'h2, 5'b00100, "idle2");
    branch(16'h0050, 16'h0050, 5'b10100, "br50");
    do_reset("reset_mid");
    for (int i = 1; i <= 5; i++) begin
      epc = 16'(i);
      idle(epc, 5'b00100, "post_reset_idle");
    end

`ifdef RAS_EN
    call(16'd40, 16'd40, 5'b10000, "call40");
    ret(16'h0, 16'd6, 5'b10100, "ret_to6");
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0077, 16'd7, 5'b00100, "jump_not_taken");
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0099, 16'd8, 5'b00100, "idea_no_valid");
    for (int i = 0; i < 9; i++) begin
      tgt = 16'(32'h100 + 16 * i);
      call(tgt, tgt, {1'b1, (i >= 7), 1'b0, (i == 8), 1'b0}, "nested_call");
    end
    for (int j = 0; j < 8; j++) begin
      k = 7 - j;
      epc = (k == 0) ? 16'd9 : 16'(32'h100 + 16 * (k - 1) + 1);
      ret(16'h0, epc, {1'b1, 1'b0, (j == 7), 1'b1, 1'b0}, "unwind_ret");
    end
    ret(16'h0, 16'd10, 5'b00111, "ret_underflow");
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0100, 16'd10, 5'b00111, "stall_br1");
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0100, 16'd10, 5'b00111, "stall_br2");
    branch(16'h0100, 16'h0100, 5'b10111, "br_after_stall");
    branch(16'h0100, 16'h0100, 5'b10111, "br_self");
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0300, 16'h0100, 5'b00111, "stall_call");
    branch(16'hFFFF, 16'hFFFF, 5'b10111, "br_ffff");
    idle(16'h0000, 5'b00111, "wrap_idle");
    branch(16'hFFFF, 16'hFFFF, 5'b10111, "br_ffff2");
    call(16'h0200, 16'h0200, 5'b10011, "call_at_ffff");
    ret(16'h0, 16'h0000, 5'b10111, "ret_wrapped");
    do_reset("reset_clears_sticky");
    idle(16'h1, 5'b00100, "idle_after_reset");
`else
    call(16'd40, 16'd40, 5'b10100, "call40");
    ret(16'h0020, 16'h0020, 5'b10100, "ret_target");
    ret(16'h0033, 16'h0033, 5'b10100, "ret_no_unf");
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0077, 16'h0034, 5'b00100, "jump_not_taken");
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0099, 16'h0035, 5'b00100, "idea_no_valid");
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0100, 16'h0035, 5'b00100, "stall_br1");
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0100, 16'h0035, 5'b00100, "stall_br2");
    branch(16'h0100, 16'h0100, 5'b10100, "br_after_stall");
    branch(16'h0100, 16'h0100, 5'b10100, "br_self");
    branch(16'hFFFF, 16'hFFFF, 5'b10100, "br_ffff");
    idle(16'h0000, 5'b00100, "wrap_idle");
    branch(16'hFFFF, 16'hFFFF, 5'b10100, "br_ffff2");
    call(16'h0200, 16'h0200, 5'b10100, "call_at_ffff");
`endif

    idle(16'h0, 5'b00000, "drain_dummy");
    // The drain entry only advances one cycle; drop it before it reaches the monitor.
    void'(exp_q.pop_back());
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
